serial_add_recover: RTL and testbench
=====================================

// Module: serial_add_recover
// PURPOSE
//  Bit-serial full-adder that inverts the full subtractor: reconstructs minuend A from difference D
//  and subtrahend S, LSB first: A = D + S + cin.
//  Sits at the receive end of the bit-serial subtract path.
//  Accumulates one WIDTH-bit word over WIDTH accepted beats and presents it in parallel with a
//  valid/ready handshake.
// PARAMETERS
//  WIDTH     8   bits per word (>=1)
//  CNT_W     $clog2(WIDTH+1)   bit-counter width (derived, not overridden)
// PORTS
//  clk        input   1      rising-edge clock, sole clock
//  rst        input   1      synchronous, active-high reset
//  in_valid   input   1      beat present on in_d/in_s
//  in_ready   output  1      block accepts beat this cycle
//  in_first   input   1      beat is bit 0 of a new word; qualified by in_valid
//  in_cin     input   1      carry-in (original subtract borrow-in), sampled only on a first beat
//  in_d       input   1      difference bit
//  in_s       input   1      subtrahend bit
//  out_valid  output  1      out_word/out_carry hold a complete word
//  out_ready  input   1      consumer takes word when out_valid && out_ready
//  out_word   output  WIDTH  reconstructed minuend, bit0 = first beat
//  out_carry  output  1      carry out of MSB (overflow of D+S+cin)
//  err_abort  output  1      1-cycle pulse: partial word discarded by early in_first
// BEHAVIOUR
//  Beat accepted  <=>  in_valid && in_ready.
//  in_ready = !out_valid || out_ready: same-cycle drain and refill is allowed.
//  Reset: state=IDLE, cnt=0, carry=0, shreg=0, out_valid=0, out_word=0, out_carry=0, err_abort=0.
//  Reset mid-word discards the partial word; no output.
//  FSM (states in the shared package):
//   IDLE:  accepted beat with in_first=1 -> ACCUM. Sum bit uses in_cin as carry; cnt=1.
//          Accepted beat with in_first=0 is dropped silently.
//   ACCUM: each accepted beat: sum = d^s^c, carry <= maj(d,s,c).
//          shreg <= {sum, shreg[WIDTH-1:1]}; cnt++.
//          Accepted beat with in_first=1 while cnt!=0: pulse err_abort.
//          That beat restarts the word as bit 0 with in_cin; cnt=1.
//   On the WIDTH-th beat: out_word <= final shreg, out_carry <= carry, out_valid <= 1 next cycle.
//   Then -> IDLE (cnt=0).
//  Latency: out_valid rises 1 cycle after the WIDTH-th beat is accepted.
//  out_valid stays high with out_word stable until out_ready.
//  Backpressure: while out_valid && !out_ready, in_ready=0, so no beats are lost.
//  Accumulation of the next word may start in the same cycle the previous word is consumed.
//  WIDTH=1: every first beat completes a word. out_word=d^s^cin, out_carry=maj(d,s,cin).
//  Arithmetic is modulo 2^WIDTH; the bit above is out_carry. No sign handling.
//  Gaps (in_valid=0) inside a word are legal; state holds.
// STRUCTURE
//  Package serial_pkg:
//   state enum {IDLE, ACCUM};
//   function fa_sum(d,s,c) / fa_carry(d,s,c);
//   default WIDTH constant.
//  Sub-module: serial_fa_cell (combinational 1-bit full adder, sum/carry); one instance.
//  Top holds FSM, bit counter, shift register and output register.
// TESTING
//  1. WIDTH=8; D=8'h05, S=8'h03, cin=0, 8 back-to-back beats, out_ready=1.
//     -> out_word=8'h08, out_carry=0, out_valid 1 cycle after beat 8.
//  2. D=8'hFF, S=8'h01, cin=1 -> out_word=8'h01, out_carry=1.
//  3. WIDTH=1; all 8 combos of {d,s,cin}.
//     -> {out_carry,out_word} = d+s+cin, each matching the full-subtractor truth table inverted.
//  4. out_ready=0 for 5 cycles after a word completes.
//     -> in_ready=0, out_word stable; new word 8'hAA streams in after release with no bit lost.
//  5. in_first at beat 4 of a word.
//     -> err_abort single pulse; next output equals the restarted word only.
//  6. rst=1 at beat 5, then a full word D=8'h10, S=8'h20.
//     -> all outputs 0 during reset; out_word=8'h30 with no residue.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and full-adder helpers for the bit-serial add/recover path.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic logic fa_sum(input logic d, input logic s, input logic c);
        return d ^ s ^ c;
    endfunction

    function automatic logic fa_carry(input logic d, input logic s, input logic c);
        return (d & s) | (d & c) | (s & c);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder used once per accepted beat.
module serial_fa_cell
    import serial_pkg::*;
(
    input  logic d,
    input  logic s,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = fa_sum(d, s, c);
    assign carry = fa_carry(d, s, c);

endmodule

// File: rtl/serial_add_recover.sv
// Bit-serial adder rebuilding minuend A = D + S + cin, LSB first, one word per WIDTH beats.
module serial_add_recover
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_cin,
    input  logic             in_d,
    input  logic             in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_carry,
    output logic             err_abort
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   shreg;

    logic               accept;
    logic               use_beat;
    logic               c_in;
    logic               sum;
    logic               carry_nxt;
    logic               word_done;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [WIDTH-1:0]   shreg_base;
    logic [WIDTH-1:0]   shreg_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Non-first beats arriving while idle belong to no word and are dropped.
    assign use_beat = accept && (in_first || (state == ACCUM));

    // A first beat restarts the word: carry from in_cin, empty shift register, count from zero.
    always_comb begin
        c_in       = 1'b0;
        cnt_base   = '0;
        shreg_base = '0;
        if (in_first) begin
            c_in       = in_cin;
            cnt_base   = '0;
            shreg_base = '0;
        end else begin
            c_in       = carry;
            cnt_base   = cnt;
            shreg_base = shreg;
        end
        cnt_nxt   = cnt_base + CNT_W'(1);
        word_done = (cnt_nxt == CNT_W'(WIDTH));
    end

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign shreg_nxt = sum;
        end else begin : g_shift_wn
            assign shreg_nxt = {sum, shreg_base[WIDTH-1:1]};
        end
    endgenerate

    serial_fa_cell u_fa (
        .d     (in_d),
        .s     (in_s),
        .c     (c_in),
        .sum   (sum),
        .carry (carry_nxt)
    );

    // FSM, bit counter, shift register and registered word output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            shreg     <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_carry <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            err_abort <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (use_beat) begin
                if (in_first && (state == ACCUM)) begin
                    err_abort <= 1'b1;
                end
                if (word_done) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    carry     <= 1'b0;
                    shreg     <= '0;
                    out_word  <= shreg_nxt;
                    out_carry <= carry_nxt;
                    out_valid <= 1'b1;
                end else begin
                    state <= ACCUM;
                    cnt   <= cnt_nxt;
                    carry <= carry_nxt;
                    shreg <= shreg_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_recover.sv
// Directed bench for serial_add_recover: an 8-bit and a 1-bit instance, scoreboard-checked.
module tb_serial_add_recover;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, in_first, in_cin, in_d, in_s;
    logic       out_valid, out_ready, out_carry, err_abort;
    logic [7:0] out_word;

    logic       in_valid1, in_ready1, in_first1, in_cin1, in_d1, in_s1;
    logic       out_valid1, out_ready1, out_carry1, err_abort1;
    logic [0:0] out_word1;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_add_recover #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_cin(in_cin), .in_d(in_d), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_carry(out_carry), .err_abort(err_abort)
    );

    serial_add_recover #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_first(in_first1),
        .in_cin(in_cin1), .in_d(in_d1), .in_s(in_s1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_word(out_word1), .out_carry(out_carry1), .err_abort(err_abort1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] d, input logic [7:0] s, input logic c);
        return {1'b0, d} + {1'b0, s} + {8'd0, c};
    endfunction

    task automatic beat(input logic d, input logic s, input logic c, input logic f);
        int n = 0;
        in_valid = 1'b1;
        in_d     = d;
        in_s     = s;
        in_cin   = c;
        in_first = f;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input logic [7:0] s, input logic c,
                             input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            beat(d[i], s[i], c, (i == 0));
        end
    endtask

    // Scoreboard for the 8-bit instance: compare at every handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (q8.size() != 0) else begin
                errors++;
                $error("FAIL dut8_unexpected_word: observed %0h expected none", {out_carry, out_word});
            end
            if (q8.size() != 0) begin
                check("dut8_word", {23'd0, out_carry, out_word}, {23'd0, q8.pop_front()});
            end
        end
    end

    // Scoreboard for the 1-bit instance.
    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            checks++;
            assert (q1.size() != 0) else begin
                errors++;
                $error("FAIL dut1_unexpected_word: observed %0h expected none", {out_carry1, out_word1});
            end
            if (q1.size() != 0) begin
                check("dut1_word", {30'd0, out_carry1, out_word1}, {30'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        logic [1:0] sum1;
        rst = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_cin = 1'b0; in_d = 1'b0; in_s = 1'b0;
        in_valid1 = 1'b0; in_first1 = 1'b0; in_cin1 = 1'b0; in_d1 = 1'b0; in_s1 = 1'b0;
        out_ready = 1'b1;
        out_ready1 = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", {24'd0, out_word}, 32'd0);
        check("rst_out_carry", {31'd0, out_carry}, 32'd0);
        check("rst_err_abort", {31'd0, err_abort}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 05 + 03, latency to out_valid
        q8.push_back(model8(8'h05, 8'h03, 1'b0));
        send_bits(8'h05, 8'h03, 1'b0, 0, 6);
        check("t1_not_early", {31'd0, out_valid}, 32'd0);
        send_bits(8'h05, 8'h03, 1'b0, 7, 7);
        check("t1_latency", {31'd0, out_valid}, 32'd1);
        check("t1_word", {24'd0, out_word}, 32'h08);
        check("t1_no_abort", {31'd0, err_abort}, 32'd0);
        tick();
        check("t1_drained", {31'd0, out_valid}, 32'd0);

        // FF + 01 + 1 overflows into out_carry
        q8.push_back(model8(8'hFF, 8'h01, 1'b1));
        send_bits(8'hFF, 8'h01, 1'b1, 0, 7);
        check("t2_carry", {31'd0, out_carry}, 32'd1);
        tick(); tick();

        // WIDTH=1: every first beat completes a word
        for (int k = 0; k < 8; k++) begin
            sum1 = {1'b0, k[0]} + {1'b0, k[1]} + {1'b0, k[2]};
            q1.push_back(sum1);
            in_valid1 = 1'b1; in_first1 = 1'b1;
            in_d1 = k[0]; in_s1 = k[1]; in_cin1 = k[2];
            tick();
            in_valid1 = 1'b0;
            check("t3_valid", {31'd0, out_valid1}, 32'd1);
        end
        tick(); tick();

        // backpressure: word held, next word's first beat waits
        out_ready = 1'b0;
        q8.push_back(model8(8'h12, 8'h34, 1'b0));
        send_bits(8'h12, 8'h34, 1'b0, 0, 7);
        in_valid = 1'b1; in_first = 1'b1; in_d = 1'b0; in_s = 1'b0; in_cin = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("t4_valid_held", {31'd0, out_valid}, 32'd1);
            check("t4_word_stable", {24'd0, out_word}, 32'h46);
            tick();
        end
        out_ready = 1'b1;
        q8.push_back(model8(8'hAA, 8'h00, 1'b0));
        send_bits(8'hAA, 8'h00, 1'b0, 0, 7);
        check("t4_aa", {24'd0, out_word}, 32'hAA);
        tick(); tick();

        // early in_first aborts the partial word
        q8.push_back(model8(8'h3C, 8'h0F, 1'b1));
        send_bits(8'h77, 8'h11, 1'b0, 0, 2);
        check("t5_no_abort_yet", {31'd0, err_abort}, 32'd0);
        beat(1'b0, 1'b1, 1'b1, 1'b1);
        check("t5_abort_pulse", {31'd0, err_abort}, 32'd1);
        beat(1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_abort_single", {31'd0, err_abort}, 32'd0);
        send_bits(8'h3C, 8'h0F, 1'b1, 2, 7);
        check("t5_word", {24'd0, out_word}, 32'h4C);
        tick(); tick();

        // reset mid-word, then a clean word
        send_bits(8'h55, 8'h0F, 1'b0, 0, 4);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_word", {24'd0, out_word}, 32'd0);
        check("t6_rst_carry", {31'd0, out_carry}, 32'd0);
        check("t6_rst_abort", {31'd0, err_abort}, 32'd0);
        tick();
        rst = 1'b0;
        q8.push_back(model8(8'h10, 8'h20, 1'b0));
        send_bits(8'h10, 8'h20, 1'b0, 0, 7);
        check("t6_word", {24'd0, out_word}, 32'h30);
        tick(); tick(); tick();

        check("q8_empty", q8.size(), 32'd0);
        check("q1_empty", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
